// File: rtl/led_chaser_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_chaser_gen
//  Description : Parametrised LED pattern generator. A prescaler enable
//                advances a position register once every DIV clocks; the
//                position is decoded into ROTATE, BOUNCE or FILL patterns.
//                Exports one-cycle step and wrap strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_chaser_gen #(
  parameter int N_LED = 8,
  parameter int DIV   = 5_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic [N_LED-1:0] led,
  output logic             step,
  output logic             wrap
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW = $clog2(N_LED);

  localparam logic [CW-1:0] C_CNT_MAX = CW'(DIV - 1);
  localparam logic [PW-1:0] C_POS_MAX = PW'(N_LED - 1);

  typedef enum logic [1:0] {
    M_ROTATE = 2'b00,
    M_BOUNCE = 2'b01,
    M_FILL   = 2'b10,
    M_RSVD   = 2'b11
  } mode_t;

  typedef enum logic {
    BD_UP = 1'b0,
    BD_DN = 1'b1
  } bdir_t;

  logic [CW-1:0] cnt_q,  cnt_d;
  logic [PW-1:0] pos_q,  pos_d;
  bdir_t         bdir_q, bdir_d;
  mode_t         mode_q, mode_d;
  logic          dir_q,  dir_d;
  logic          step_q, step_d;
  logic          wrap_q, wrap_d;

  logic          tick;
  logic          mode_chg;
  logic [N_LED-1:0] led_dec;

  // Prescaler terminal count; stop suppresses the tick as well as the count.
  assign tick     = !stop && (cnt_q == C_CNT_MAX);
  assign mode_chg = (mode_t'(mode) != mode_q);

  // Next-state: mode change restarts the pattern and outranks a pending tick.
  always_comb begin
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    bdir_d = bdir_q;
    mode_d = mode_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    wrap_d = 1'b0;

    if (!stop) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    if (mode_chg) begin
      mode_d = mode_t'(mode);
      dir_d  = dir;
      pos_d  = '0;
      bdir_d = BD_UP;
      cnt_d  = '0;
    end else if (tick) begin
      dir_d  = dir;
      step_d = 1'b1;
      case (mode_q)
        M_BOUNCE: begin
          // Endpoints reverse direction immediately so they are never repeated.
          if (bdir_q == BD_UP) begin
            if (pos_q == C_POS_MAX) begin
              bdir_d = BD_DN;
              pos_d  = C_POS_MAX - PW'(1);
            end else begin
              pos_d  = pos_q + PW'(1);
            end
          end else begin
            if (pos_q == '0) begin
              bdir_d = BD_UP;
              pos_d  = PW'(1);
            end else begin
              pos_d  = pos_q - PW'(1);
            end
          end
        end
        M_FILL: begin
          pos_d = (pos_q == C_POS_MAX) ? '0 : pos_q + PW'(1);
        end
        default: begin
          // ROTATE and the reserved encoding share one behaviour.
          if (dir) begin
            pos_d = (pos_q == '0) ? C_POS_MAX : pos_q - PW'(1);
          end else begin
            pos_d = (pos_q == C_POS_MAX) ? '0 : pos_q + PW'(1);
          end
        end
      endcase
      wrap_d = (pos_d == '0);
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      pos_q  <= '0;
      bdir_q <= BD_UP;
      mode_q <= M_ROTATE;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      bdir_q <= bdir_d;
      mode_q <= mode_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  // LED decode from registered state only (no input-to-output path).
  always_comb begin
    led_dec = '0;
    for (int i = 0; i < N_LED; i++) begin
      if (mode_q == M_FILL) begin
        if (dir_q) begin
          led_dec[i] = (i >= (N_LED - 1 - int'(pos_q)));
        end else begin
          led_dec[i] = (i <= int'(pos_q));
        end
      end else begin
        led_dec[i] = (i == int'(pos_q));
      end
    end
  end

  assign led  = led_dec;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_led_chaser_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_chaser_gen
//  Description : Directed, table-driven bench for led_chaser_gen with
//                N_LED=8, DIV=4, plus a small N_LED=2, DIV=1 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_chaser_gen;

  logic       clk;
  logic       rst;
  logic       stop;
  logic [1:0] mode;
  logic       dir;
  logic [7:0] led;
  logic       step;
  logic       wrap;
  logic [1:0] led2;
  logic       step2;
  logic       wrap2;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic       stop;
    logic [1:0] mode;
    logic       dir;
    int         cyc;
    logic [7:0] led;
    logic       step;
    logic       wrap;
  } vec_t;

  vec_t vecs[$];
  int   split_idx;

  led_chaser_gen #(.N_LED(8), .DIV(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .stop (stop),
    .mode (mode),
    .dir  (dir),
    .led  (led),
    .step (step),
    .wrap (wrap)
  );

  led_chaser_gen #(.N_LED(2), .DIV(1)) dut2 (
    .clk  (clk),
    .rst  (rst),
    .stop (1'b0),
    .mode (2'b00),
    .dir  (1'b0),
    .led  (led2),
    .step (step2),
    .wrap (wrap2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic s, input logic [1:0] m, input logic d,
                     input int c, input logic [7:0] l, input logic st,
                     input logic w);
    vec_t v;
    v.stop = s; v.mode = m; v.dir = d; v.cyc = c;
    v.led = l; v.step = st; v.wrap = w;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [9:0] act, input logic [9:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got led/step/wrap=%h/%b/%b, want %h/%b/%b",
               nm, act[9:2], act[1], act[0], exp_v[9:2], exp_v[1], exp_v[0]);
    end
  endtask

  task automatic apply(input int idx);
    vec_t v;
    v = vecs[idx];
    stop = v.stop; mode = v.mode; dir = v.dir;
    repeat (v.cyc) @(posedge clk);
    #1;
    check($sformatf("vec[%0d]", idx), {led, step, wrap}, {v.led, v.step, v.wrap});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    stop  = 1'b0;
    mode  = 2'b00;
    dir   = 1'b0;
    rst   = 1'b1;

    // ROTATE toward MSB: one step per 4 cycles, wrap back at led=01
    add(0,0,0,3,8'h01,0,0);
    add(0,0,0,1,8'h02,1,0);
    add(0,0,0,1,8'h02,0,0);
    add(0,0,0,3,8'h04,1,0);
    add(0,0,0,4,8'h08,1,0);
    add(0,0,0,4,8'h10,1,0);
    add(0,0,0,4,8'h20,1,0);
    add(0,0,0,4,8'h40,1,0);
    add(0,0,0,4,8'h80,1,0);
    add(0,0,0,4,8'h01,1,1);
    add(0,0,0,1,8'h01,0,0);
    // ROTATE toward LSB
    add(0,0,1,3,8'h80,1,0);
    add(0,0,1,4,8'h40,1,0);
    add(0,0,1,4,8'h20,1,0);
    add(0,0,1,4,8'h10,1,0);
    add(0,0,1,4,8'h08,1,0);
    add(0,0,1,4,8'h04,1,0);
    add(0,0,1,4,8'h02,1,0);
    add(0,0,1,4,8'h01,1,1);
    // BOUNCE: mode change, then full 14-step period (dir ignored)
    add(0,1,0,1,8'h01,0,0);
    add(0,1,0,3,8'h01,0,0);
    add(0,1,0,1,8'h02,1,0);
    add(0,1,1,4,8'h04,1,0);
    add(0,1,1,4,8'h08,1,0);
    add(0,1,1,4,8'h10,1,0);
    add(0,1,1,4,8'h20,1,0);
    add(0,1,1,4,8'h40,1,0);
    add(0,1,1,4,8'h80,1,0);
    add(0,1,1,4,8'h40,1,0);
    add(0,1,1,4,8'h20,1,0);
    add(0,1,1,4,8'h10,1,0);
    add(0,1,1,4,8'h08,1,0);
    add(0,1,1,4,8'h04,1,0);
    add(0,1,1,4,8'h02,1,0);
    add(0,1,1,4,8'h01,1,1);
    add(0,1,1,4,8'h02,1,0);
    add(0,1,1,4,8'h04,1,0);
    add(0,1,1,4,8'h08,1,0);
    add(0,1,1,4,8'h10,1,0);
    add(0,1,1,4,8'h20,1,0);
    // BOUNCE pos=5 mid-step -> FILL
    add(0,1,1,1,8'h20,0,0);
    add(0,2,0,1,8'h01,0,0);
    add(0,2,0,3,8'h01,0,0);
    add(0,2,0,1,8'h03,1,0);
    add(0,2,0,4,8'h07,1,0);
    add(0,2,0,4,8'h0F,1,0);
    add(0,2,0,4,8'h1F,1,0);
    add(0,2,0,4,8'h3F,1,0);
    add(0,2,0,4,8'h7F,1,0);
    add(0,2,0,4,8'hFF,1,0);
    add(0,2,0,4,8'h01,1,1);
    // FILL toward LSB: dir change mid-step is invisible until the step
    add(0,2,1,2,8'h01,0,0);
    add(0,2,1,2,8'hC0,1,0);
    add(0,2,1,4,8'hE0,1,0);
    add(0,2,1,4,8'hF0,1,0);
    add(0,2,1,4,8'hF8,1,0);
    add(0,2,1,4,8'hFC,1,0);
    add(0,2,1,4,8'hFE,1,0);
    add(0,2,1,4,8'hFF,1,0);
    add(0,2,1,4,8'h80,1,1);
    add(0,2,0,2,8'h80,0,0);
    add(0,2,1,2,8'hC0,1,0);
    // stop for 10 cycles at cnt=2, then step 2 cycles after release
    add(0,0,0,1,8'h01,0,0);
    add(0,0,0,2,8'h01,0,0);
    add(1,0,0,10,8'h01,0,0);
    add(0,0,0,1,8'h01,0,0);
    add(0,0,0,1,8'h02,1,0);
    // stop at cnt=DIV-1
    add(0,0,0,3,8'h02,0,0);
    add(1,0,0,5,8'h02,0,0);
    add(0,0,0,1,8'h04,1,0);
    // mode change while stopped
    add(1,1,0,1,8'h01,0,0);
    add(1,1,0,3,8'h01,0,0);
    add(0,1,0,3,8'h01,0,0);
    add(0,1,0,1,8'h02,1,0);
    // reserved mode behaves as ROTATE
    add(0,3,0,1,8'h01,0,0);
    add(0,3,0,3,8'h01,0,0);
    add(0,3,0,1,8'h02,1,0);
    add(0,3,1,4,8'h01,1,1);
    add(0,3,1,4,8'h80,1,0);
    add(0,3,1,4,8'h40,1,0);
    split_idx = vecs.size();
    // after asynchronous reset: first step on the DIV-th edge
    add(0,0,0,3,8'h01,0,0);
    add(0,0,0,1,8'h02,1,0);

    // DIV=1, N_LED=2: step every cycle, wrap every other
    @(posedge clk); #1;
    check("reset2", {6'd0, led2, step2, wrap2}, {6'd0, 2'b01, 1'b0, 1'b0});
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("div1_edge%0d", k), {6'd0, led2, step2, wrap2},
            {6'd0, ((k % 2) == 1) ? 2'b10 : 2'b01, 1'b1, ((k % 2) == 0)});
    end

    // main instance: fresh reset, then the vector table
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset", {led, step, wrap}, {8'h01, 1'b0, 1'b0});
    rst = 1'b0;
    for (int i = 0; i < split_idx; i++) apply(i);

    // asynchronous reset mid-cycle while step is high
    check("pre_rst", {led, step, wrap}, {8'h40, 1'b1, 1'b0});
    #2 rst = 1'b1;
    #1;
    check("async_rst", {led, step, wrap}, {8'h01, 1'b0, 1'b0});
    mode = 2'b00; dir = 1'b0; stop = 1'b0;
    #2 rst = 1'b0;
    for (int i = split_idx; i < vecs.size(); i++) apply(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_chaser_gen.md
# led_chaser_gen

Parametrised LED pattern generator that succeeds the fixed 8-LED walking-one chaser. It supports N LEDs, a configurable step period, and four display modes: rotate, bounce, fill and reserved. The whole block runs on one clock; step timing comes from an internal prescaler enable, not a derived clock. It drives the board LED bank directly and exports step/wrap strobes for other logic.

## Interface
- N_LED, 8, number of LEDs (≥2)
- DIV, 5_000_000, clk cycles per pattern step (≥1)
- clk  in  1  system clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- stop  in  1  1 = freeze pattern and prescaler
- mode  in  2  00 ROTATE, 01 BOUNCE, 10 FILL, 11 reserved (behaves as ROTATE)
- dir  in  1  0 = toward MSB, 1 = toward LSB (ROTATE, FILL; ignored in BOUNCE)
- led  out  N_LED  LED drive, 1 = on
- step  out  1  one-cycle pulse when the pattern advances
- wrap  out  1  one-cycle pulse when a step lands on pos = 0

## Operation
- State registers:
  - cnt: prescaler, 0..DIV-1, width clog2(DIV), min 1.
  - pos: 0..N_LED-1.
  - bdir: bounce direction, up/down.
  - mode_q, dir_q.
  - step, wrap.
- Reset values: cnt=0, pos=0, bdir=up, mode_q=00, dir_q=0, step=0, wrap=0. led therefore resets to bit0 only (…0001).
- Prescaler:
  - stop=0: cnt increments. At cnt==DIV-1 it wraps to 0 and raises internal tick for that cycle.
  - stop=1: cnt holds and no tick occurs.
- Mode change (mode ≠ mode_q) has priority over tick. On the next edge: mode_q←mode, dir_q←dir, pos←0, bdir←up, cnt←0. step and wrap are not asserted. This applies even while stop=1.
- On tick, with no mode change, dir_q←dir, then pos updates by mode_q:
  - ROTATE, dir=0: pos←(pos+1) mod N_LED.
  - ROTATE, dir=1: pos←(pos-1) mod N_LED. pos 0 goes to N_LED-1.
  - BOUNCE: moves ±1 per bdir.
    - At pos=N_LED-1 going up: bdir←down, pos←N_LED-2.
    - At pos=0 going down: bdir←up, pos←1.
    - Endpoints are never shown twice in a row. Cycle length is 2·(N_LED-1) steps.
  - FILL: pos←(pos+1) mod N_LED. Uses the new dir.
- led decode is a function of registered state only, with no input-to-led combinational path:
  - ROTATE and BOUNCE: one-hot, bit pos.
  - FILL, dir_q=0: bits [pos:0] set.
  - FILL, dir_q=1: bits [N_LED-1:N_LED-1-pos] set.
- A dir change between ticks has no visible effect until the next tick.
- step←1 on the edge where pos updates because of a tick; otherwise 0.
- wrap←1 on that same edge if the new pos==0.

## Timing
- With stop=0 from reset release, the first pos update happens on the DIV-th rising edge. Subsequent updates occur every DIV cycles.
- DIV=1: one step per cycle.
- led, step and wrap all change on the same edge as pos.
- step and wrap are high for exactly one cycle.
- Mode change: led shows the pos=0 pattern one edge after mode differs. The next step follows DIV cycles later.
- stop asserted for k cycles stretches the current step by exactly k cycles, including when asserted at cnt==DIV-1.
- Asynchronous rst mid-operation: led returns to …0001 and step/wrap go to 0 immediately, without waiting for clk.

## Test plan
- N_LED=8, DIV=4, mode=00, dir=0, stop=0, release rst → led 01,02,04…80,01, changing every 4 cycles. step pulses each change. wrap fires alongside led=01 after 32 cycles.
- Same setup with dir=1 → led 01,80,40,20…02,01. wrap fires on each return to 01.
- mode=01 → led 01,02…80,40…02,01,02. No duplicated endpoint. 14-step period. wrap only when led=01.
- mode=10:
  - dir=0 → 01,03,07…FF,01.
  - dir=1 → 80,C0,E0…FF,80.
  - Toggle dir mid-step → led unchanged until the next step.
- stop=1 for 10 cycles while cnt=2 → led and cnt frozen, no step. After release, the next step comes exactly 2 cycles later.
- In BOUNCE at pos=5, switch mode to 10 → next edge led=01, no step, next step 4 cycles later. Assert rst asynchronously mid-step → led=01 and step=0 before the next clk edge.
